fetch_queue: RTL



---
 rtl/riscv_pkg.sv | 16 +
 rtl/fq_fifo.sv | 76 +++++++
 rtl/fetch_queue.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side constants and the fetch queue entry layout.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0]             insn;
        logic [XLEN_DEFAULT-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Generic synchronous FIFO, pointer based with an extra wrap bit.
// Clear has priority over push and pop; push while full is accepted only
// together with a pop.
module fq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q;
    logic [PTR_W:0]   rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Status flags derived from the wrap-bit pointers.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        count   = wr_ptr_q - rd_ptr_q;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: issues IMEM requests under a credit limit,
// buffers responses in a DEPTH-entry FIFO and presents the head to decode.
// An E-stage redirect flushes the FIFO and discards responses still in
// flight for the old path.
// Optional: FETCH_QUEUE_FASTPATH_EN lets a response arriving into an empty
// FIFO drive the decode outputs in the same cycle.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN            = XLEN_DEFAULT,
    parameter int unsigned      DEPTH           = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0]  RESET_PC        = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            CLK,
    input  logic            RSTN,
    output logic [XLEN-1:0] IADDR,
    output logic            IREQ,
    input  logic [31:0]     IDATA,
    input  logic            IVALID,
    input  logic            REDIR_E,
    input  logic [XLEN-1:0] REDIR_PC,
    input  logic            D_STALL,
    output logic            FD_VALID,
    output logic [31:0]     IR,
    output logic [XLEN-1:0] FD_PC,
    output logic [XLEN-1:0] FD_PC4
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned ENTRY_W = 32 + XLEN;

    logic [XLEN-1:0]    fetch_pc_q;
    logic [XLEN-1:0]    fetch_pc_d;
    logic [XLEN-1:0]    tag_q;
    logic [XLEN-1:0]    tag_d;
    logic [OUT_W-1:0]   outstanding_q;
    logic [OUT_W-1:0]   outstanding_d;
    logic [OUT_W-1:0]   drop_q;
    logic [OUT_W-1:0]   drop_d;
    logic               run_q;
    logic               run_d;

    logic [XLEN-1:0]    redir_tgt;
    logic               ireq_int;
    logic               resp;
    logic               accept;
    logic               bypass;
    logic               head_valid;
    logic [ENTRY_W-1:0] head_entry;
    logic               pop_int;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_rdata;

    // Buffered {insn, pc} entries.
    fq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (REDIR_E),
        .wdata ({IDATA, tag_q}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Request credit, response acceptance and head selection.
    always_comb begin
        redir_tgt = REDIR_PC & ~XLEN'(3);
        ireq_int  = run_q && !REDIR_E &&
                    (32'(outstanding_q) < 32'(MAX_OUTSTANDING)) &&
                    ((32'(fifo_count) + 32'(outstanding_q)) < 32'(DEPTH));
        // A response with nothing in flight is unsolicited and ignored.
        resp      = IVALID && (outstanding_q != '0);
        accept    = resp && (drop_q == '0) && !REDIR_E;
        bypass    = 1'b0;
`ifdef FETCH_QUEUE_FASTPATH_EN
        bypass    = accept && fifo_empty;
`endif
        head_valid = !fifo_empty || bypass;
        head_entry = fifo_empty ? {IDATA, tag_q} : fifo_rdata;
        pop_int    = head_valid && !D_STALL;
        fifo_pop   = pop_int && !fifo_empty;
        // A bypassed response consumed by decode never enters the FIFO.
        fifo_push  = accept && !(bypass && !D_STALL) && (!fifo_full || fifo_pop);
    end

    // Decode-facing outputs; NOP and zero PCs while nothing is valid.
    always_comb begin
        IREQ     = ireq_int;
        IADDR    = fetch_pc_q;
        FD_VALID = head_valid;
        IR       = NOP_INSN;
        FD_PC    = '0;
        FD_PC4   = '0;
        if (head_valid) begin
            IR     = head_entry[ENTRY_W-1:XLEN];
            FD_PC  = head_entry[XLEN-1:0];
            FD_PC4 = head_entry[XLEN-1:0] + XLEN'(4);
        end
    end

    // Fetch PC, tag, credit and drop bookkeeping.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        tag_d         = tag_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        run_d         = 1'b1;
        if (REDIR_E) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d    = redir_tgt;
            tag_d         = redir_tgt;
            outstanding_d = outstanding_q - OUT_W'(resp);
            drop_d        = outstanding_q - OUT_W'(resp);
        end else begin
            if (ireq_int) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (accept) begin
                tag_d = tag_q + XLEN'(4);
            end
            if (resp && (drop_q != '0)) begin
                drop_d = drop_q - OUT_W'(1);
            end
            outstanding_d = outstanding_q + OUT_W'(ireq_int) - OUT_W'(resp);
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fetch_pc_q    <= RESET_PC;
            tag_q         <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            run_q         <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            run_q         <= run_d;
        end
    end

endmodule
